// File: rtl/snoop_pkg.sv
// snoop_pkg: message codes, controller states and sizing helpers shared by the snoop bus.
package snoop_pkg;
    typedef enum int {
        MSG_NONE       = 0,
        MSG_WRITE_MISS = 1,
        MSG_READ_MISS  = 2,
        MSG_INVALIDATE = 3,
        MSG_WRITEBACK  = 4
    } msg_e;

    typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_WB, S_RESP} state_t;

    function automatic int idw(input int n);
        return $clog2(n);
    endfunction

    function automatic logic msg_legal(input int m);
        return m >= MSG_WRITE_MISS && m <= MSG_WRITEBACK;
    endfunction
endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = |req;
        // descending scan so the closest request after ptr wins last
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IW'((int'(ptr) + k) % N);
                gnt = N'(1) << ((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin snooping-coherence bus controller with
// owner write-back into a small line memory.
module snoop_bus_ctrl
    import snoop_pkg::*;
#(
    parameter int N_PROC = 3,
    parameter int AW = 3,
    parameter int DW = 8,
    parameter int MSG_W = 3,
    localparam int IDW = idw(N_PROC)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_PROC-1:0]   req_valid,
    input  logic [N_PROC*MSG_W-1:0] req_msg,
    input  logic [N_PROC*AW-1:0] req_addr,
    input  logic [N_PROC*DW-1:0] req_data,
    output logic [N_PROC-1:0]   grant,
    output logic                bus_valid,
    output logic [MSG_W-1:0]    bus_msg,
    output logic [AW-1:0]       bus_addr,
    output logic [IDW-1:0]      bus_src,
    input  logic [N_PROC-1:0]   snoop_mod,
    input  logic [N_PROC*DW-1:0] snoop_data,
    output logic                resp_valid,
    output logic [IDW-1:0]      resp_id,
    output logic [DW-1:0]       resp_data,
    output logic                protocol_err
);
    state_t state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, src_q, src_d, resp_id_q, resp_id_d, arb_idx, owner;
    logic [MSG_W-1:0] msg_q, msg_d, win_msg;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d, resp_data_q, resp_data_d;
    logic [N_PROC-1:0] grant_q, grant_d, elig, arb_gnt, hits;
    logic bus_valid_q, bus_valid_d, resp_valid_q, resp_valid_d, err_q, err_d, arb_any;
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] mem_d [2**AW];

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_PROC; i++)
            elig[i] = req_valid[i] && (req_msg[i*MSG_W +: MSG_W] != MSG_W'(MSG_NONE));
    end

    rr_arbiter #(.N(N_PROC)) u_arb (
        .req (elig),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign win_msg = req_msg[arb_idx*MSG_W +: MSG_W];
    assign hits = snoop_mod & ~(N_PROC'(1) << src_q);

    always_comb begin
        owner = '0;
        for (int i = N_PROC - 1; i >= 0; i--)
            if (hits[i]) owner = IDW'(i);
    end

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        src_d = src_q;
        msg_d = msg_q;
        addr_d = addr_q;
        data_d = data_q;
        err_d = err_q;
        mem_d = mem_q;
        case (state_q)
            S_IDLE: if (arb_any) begin
                ptr_d = (int'(arb_idx) == N_PROC - 1) ? '0 : arb_idx + IDW'(1);
                if (msg_legal(int'(win_msg))) begin
                    state_d = S_BCAST;
                    src_d = arb_idx;
                    msg_d = win_msg;
                    addr_d = req_addr[arb_idx*AW +: AW];
                    data_d = req_data[arb_idx*DW +: DW];
                end else begin
                    err_d = 1'b1;
                end
            end
            S_BCAST: state_d = (int'(msg_q) == MSG_WRITEBACK) ? S_WB : S_SNOOP;
            S_SNOOP: begin
                err_d = err_q | snoop_mod[src_q] | ((hits & (hits - N_PROC'(1))) != '0);
                state_d = (hits != '0) ? S_WB : S_RESP;
                data_d = (hits != '0) ? snoop_data[owner*DW +: DW] : data_q;
            end
            S_WB: begin
                mem_d[addr_q] = data_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
                src_d = '0;
                msg_d = '0;
                addr_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // outputs registered from the next state; resp sees this transaction's write-back
        grant_d = (state_q == S_IDLE && state_d == S_BCAST) ? arb_gnt : '0;
        bus_valid_d = state_d == S_BCAST;
        resp_valid_d = state_d == S_RESP;
        resp_id_d = resp_valid_d ? src_d : '0;
        resp_data_d = resp_valid_d ? mem_d[addr_d] : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q <= '0;
            src_q <= '0;
            msg_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q <= 1'b0;
            grant_q <= '0;
            bus_valid_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q <= '0;
            resp_data_q <= '0;
            mem_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            src_q <= src_d;
            msg_q <= msg_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q <= err_d;
            grant_q <= grant_d;
            bus_valid_q <= bus_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q <= resp_id_d;
            resp_data_q <= resp_data_d;
            mem_q <= mem_d;
        end
    end

    assign grant = grant_q;
    assign bus_valid = bus_valid_q;
    assign bus_msg = msg_q;
    assign bus_addr = addr_q;
    assign bus_src = src_q;
    assign resp_valid = resp_valid_q;
    assign resp_id = resp_id_q;
    assign resp_data = resp_data_q;
    assign protocol_err = err_q;
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed table, corner sequences and randomized traffic
// against a transaction-level model of the snoop bus controller.
module tb_snoop_bus_ctrl;
    localparam int N = 3, AW = 3, DW = 8, MW = 3;

    logic clock = 1'b0, reset = 1'b1;
    logic [N-1:0] req_valid = '0, snoop_mod = '0;
    logic [N*MW-1:0] req_msg = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0, snoop_data = '0;
    logic [N-1:0] grant;
    logic bus_valid, resp_valid, protocol_err;
    logic [MW-1:0] bus_msg;
    logic [AW-1:0] bus_addr;
    logic [1:0] bus_src, resp_id;
    logic [DW-1:0] resp_data;

    int checks = 0, errors = 0;
    int mem_m [8];
    bit err_m;
    int ptr_m;

    typedef struct {
        int src; int msg; int addr; int data;
        logic [N-1:0] smod; logic [N*DW-1:0] sdat;
        int lat; int rd; bit err;
    } vec_t;
    vec_t tbl [7];

    snoop_bus_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_msg(req_msg), .req_addr(req_addr), .req_data(req_data),
        .grant(grant), .bus_valid(bus_valid), .bus_msg(bus_msg), .bus_addr(bus_addr), .bus_src(bus_src),
        .snoop_mod(snoop_mod), .snoop_data(snoop_data),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req_valid = '0;
        snoop_mod = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mem_m[i] = 0;
        err_m = 1'b0;
        ptr_m = 0;
    endtask

    // Transaction-level reference: arbitrate, apply coherence rules, return expectations.
    task automatic model(input logic [N-1:0] v, input logic [N*MW-1:0] m, input logic [N*AW-1:0] a,
                         input logic [N*DW-1:0] d, input logic [N-1:0] sm, input logic [N*DW-1:0] sd,
                         output int w, output int lat, output int rd, output bit e);
        int msg, addr, o;
        logic [N-1:0] h;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && v[(ptr_m + k) % N] && m[((ptr_m + k) % N)*MW +: MW] != 0) w = (ptr_m + k) % N;
        ptr_m = (w + 1) % N;
        msg = int'(m[w*MW +: MW]);
        addr = int'(a[w*AW +: AW]);
        lat = 3;
        if (msg == 4) begin
            mem_m[addr] = int'(d[w*DW +: DW]);
        end else begin
            h = sm;
            if (h[w]) begin err_m = 1'b1; h[w] = 1'b0; end
            if ($countones(h) > 1) err_m = 1'b1;
            if (h != 0) begin
                o = -1;
                for (int i = 0; i < N; i++) if (o < 0 && h[i]) o = i;
                mem_m[addr] = int'(sd[o*DW +: DW]);
                lat = 4;
            end
        end
        rd = mem_m[addr];
        e = err_m;
    endtask

    task automatic run_txn(input logic [N-1:0] v, input logic [N*MW-1:0] m, input logic [N*AW-1:0] a,
                           input logic [N*DW-1:0] d, input logic [N-1:0] sm, input logic [N*DW-1:0] sd,
                           input int w, input int lat, input int rd, input bit e, input string tag);
        int cyc;
        @(negedge clock);
        req_valid = v; req_msg = m; req_addr = a; req_data = d;
        snoop_mod = sm; snoop_data = sd;
        cyc = 0;
        do begin @(negedge clock); cyc++; end while (grant == '0 && cyc < 8);
        chk({tag, " grant"}, 32'(grant), 32'(1 << w));
        chk({tag, " grant cycle"}, cyc, 1);
        chk({tag, " bus"}, {bus_valid, bus_msg, bus_addr, bus_src}, {1'b1, m[w*MW +: MW], a[w*AW +: AW], 2'(w)});
        req_valid = '0;
        while (!resp_valid && cyc < 12) begin @(negedge clock); cyc++; end
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " resp"}, {resp_id, resp_data}, {2'(w), 8'(rd)});
        chk({tag, " err"}, protocol_err, e);
        snoop_mod = '0;
    endtask

    initial begin
        logic [N-1:0] v, sm;
        logic [N*MW-1:0] m;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d, sd;
        logic [N-1:0] rr_exp [4];
        int w, lat, rd, ng, nresp, last_resp;
        bit e;

        tbl[0] = '{0, 2, 5, 'h11, 3'b000, 24'h0,      3, 'h00, 1'b0};
        tbl[1] = '{1, 4, 2, 'hA5, 3'b000, 24'h0,      3, 'hA5, 1'b0};
        tbl[2] = '{2, 2, 2, 'h00, 3'b000, 24'h0,      3, 'hA5, 1'b0};
        tbl[3] = '{0, 2, 4, 'h00, 3'b100, 24'h3C0000, 4, 'h3C, 1'b0};
        tbl[4] = '{1, 1, 2, 'hFF, 3'b000, 24'h0,      3, 'hA5, 1'b0};
        tbl[5] = '{2, 1, 4, 'h00, 3'b001, 24'h000077, 4, 'h77, 1'b0};
        tbl[6] = '{1, 3, 6, 'h00, 3'b011, 24'h00EE5A, 4, 'h5A, 1'b1};
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

        do_reset();
        chk("reset grant", 32'(grant), 0);
        chk("reset bus", {bus_valid, bus_msg, bus_addr, bus_src}, 0);
        chk("reset resp", {resp_valid, resp_id, resp_data}, 0);
        chk("reset err", protocol_err, 0);

        for (int t = 0; t < 7; t++) begin
            v = '0; m = '0; a = '0; d = '0;
            v[tbl[t].src] = 1'b1;
            m[tbl[t].src*MW +: MW] = MW'(tbl[t].msg);
            a[tbl[t].src*AW +: AW] = AW'(tbl[t].addr);
            d[tbl[t].src*DW +: DW] = DW'(tbl[t].data);
            run_txn(v, m, a, d, tbl[t].smod, tbl[t].sdat, tbl[t].src, tbl[t].lat, tbl[t].rd, tbl[t].err,
                    $sformatf("tbl%0d", t));
        end
        repeat (5) @(negedge clock);
        chk("err sticky", protocol_err, 1);

        // reset while the owner write-back is pending in SNOOP
        @(negedge clock);
        req_valid = 3'b001; req_msg = 9'd2; req_addr = 9'd4;
        snoop_mod = 3'b100; snoop_data = 24'h3C0000;
        @(negedge clock);
        chk("snoop-reset grant", 32'(grant), 1);
        req_valid = '0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("snoop-reset outputs", {grant, bus_valid, bus_msg, bus_addr, bus_src, resp_valid, resp_id, resp_data}, 0);
        chk("snoop-reset err", protocol_err, 0);
        @(negedge clock);
        reset = 1'b0;
        snoop_mod = '0;
        for (int i = 0; i < 8; i++) mem_m[i] = 0;
        err_m = 1'b0; ptr_m = 0;
        nresp = 0;
        repeat (5) begin @(negedge clock); if (resp_valid) nresp++; end
        chk("snoop-reset no resp", nresp, 0);
        run_txn(3'b001, 9'd2, 9'd4, 24'h0, 3'b000, 24'h0, 0, 3, 0, 1'b0, "post-reset mem4");

        // illegal code is dropped, flags an error and still moves the pointer
        do_reset();
        @(negedge clock);
        req_valid = 3'b001; req_msg = 9'd5; req_addr = 9'd1;
        ng = 0;
        repeat (4) begin @(negedge clock); if (grant != '0 || bus_valid) ng++; end
        chk("illegal no grant", ng, 0);
        chk("illegal err", protocol_err, 1);
        req_valid = '0;
        run_txn(3'b011, {3'd0, 3'd2, 3'd2}, 9'h0, 24'h0, 3'b000, 24'h0, 1, 3, 0, 1'b1, "after illegal");

        // continuously held requests rotate with one idle cycle between transactions
        do_reset();
        @(negedge clock);
        req_valid = 3'b111; req_msg = {3'd2, 3'd2, 3'd2}; req_addr = '0; snoop_mod = '0;
        ng = 0; last_resp = -100;
        for (int c = 1; c <= 60 && ng < 4; c++) begin
            @(negedge clock);
            if (grant != '0) begin
                chk($sformatf("rr grant%0d", ng), 32'(grant), 32'(rr_exp[ng]));
                if (ng > 0) chk($sformatf("rr spacing%0d", ng), c, last_resp + 2);
                ng++;
            end
            if (resp_valid) last_resp = c;
        end
        chk("rr count", ng, 4);
        req_valid = '0;

        do_reset();
        for (int r = 0; r < 40; r++) begin
            v = N'($urandom_range(1, 7));
            m = '0;
            for (int i = 0; i < N; i++) m[i*MW +: MW] = MW'($urandom_range(1, 4));
            a = N*AW'($urandom);
            d = N*DW'($urandom);
            sm = N'($urandom);
            if ($urandom_range(0, 4) != 0) sm = sm & ~v;
            sd = N*DW'($urandom);
            model(v, m, a, d, sm, sd, w, lat, rd, e);
            run_txn(v, m, a, d, sm, sd, w, lat, rd, e, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
